// File: rtl/fir_out_serializer.sv
// Buffers signed FIR samples in a small FIFO and streams each one to the host
// as two bytes, high byte first, over a valid/ack handshake.
module fir_out_serializer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ack,
    output logic              out_hi,
    input  logic              ovf_clr,
    output logic              overflow,
    output logic [3:0]        level
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_HI = 2'd1,
        SEND_LO = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [1:0]        rst_sync;
    logic              rst_int_n;
    logic [15:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [15:0]       hold, hold_next;
    logic [15:0]       in_ext;
    logic [15:0]       head;
    logic              wr_en, drop, pop, empty;
    logic              valid_next, hi_next;
    logic [7:0]        byte_next;

    // Reset asserts asynchronously but is released only on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign in_ext   = 16'($signed(in_data));
    assign in_ready = (level != 4'(DEPTH));
    assign empty    = (level == 4'd0);
    assign wr_en    = ena && in_valid && in_ready;
    assign drop     = ena && in_valid && !in_ready;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= in_ext;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        hold_next  = hold;
        valid_next = out_valid;
        byte_next  = out_byte;
        hi_next    = out_hi;
        if (ena) begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state_next = SEND_HI;
                        pop        = 1'b1;
                        hold_next  = head;
                        byte_next  = head[15:8];
                        hi_next    = 1'b1;
                        valid_next = 1'b1;
                    end
                end
                SEND_HI: begin
                    if (out_ack) begin
                        state_next = SEND_LO;
                        byte_next  = hold[7:0];
                        hi_next    = 1'b0;
                    end
                end
                SEND_LO: begin
                    if (out_ack) begin
                        if (!empty) begin
                            state_next = SEND_HI;
                            pop        = 1'b1;
                            hold_next  = head;
                            byte_next  = head[15:8];
                            hi_next    = 1'b1;
                        end else begin
                            state_next = IDLE;
                            valid_next = 1'b0;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= 4'd0;
            hold      <= 16'h0000;
            out_valid <= 1'b0;
            out_hi    <= 1'b0;
            out_byte  <= 8'h00;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            hold      <= hold_next;
            out_valid <= valid_next;
            out_hi    <= hi_next;
            out_byte  <= byte_next;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            level <= level + {3'b000, wr_en} - {3'b000, pop};
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule
